gemm_tile_sched: RTL and testbench

GEMM_TILE_SCHED -- requirements
Module: gemm_tile_sched

---
 rtl/gemm_pkg.sv | 23 ++
 rtl/gemm_tile_sched_if.sv | 44 ++++
 rtl/gemm_operand_fetch.sv | 61 ++++++
 rtl/gemm_tile_sched.sv | 166 ++++++++++++++++
 tb/tb_gemm_tile_sched.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gemm_pkg.sv
// Shared types and constants for the GEMM tile scheduler and its core:
// FSM state encoding, default tile sizes, and the job-dimension clamp.
package gemm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ELEM_START,
        FEED,
        WAIT_OUT,
        WRITE,
        FIN
    } sched_state_t;

    localparam int DEF_M_TILE = 4;
    localparam int DEF_N_TILE = 8;
    localparam int DEF_K_TILE = 16;

    // Zero selects the tile maximum; anything larger clamps to it.
    function automatic logic [15:0] clamp_dim(input logic [15:0] v, input logic [15:0] lim);
        return (v == 16'd0 || v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/gemm_tile_sched_if.sv
// Buffer-read, core and result-write bus of gemm_tile_sched; the scheduler
// is the master, the A/B buffers, MAC core and result sink are the slave.
interface gemm_tile_sched_if #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 32,
    parameter int ADDR_W    = 16
);
    logic                 a_rd_en;
    logic [ADDR_W-1:0]    a_rd_addr;
    logic [A_WIDTH-1:0]   a_rd_data;
    logic                 b_rd_en;
    logic [ADDR_W-1:0]    b_rd_addr;
    logic [B_WIDTH-1:0]   b_rd_data;

    logic                 core_start;
    logic [15:0]          core_k_tile;
    logic                 core_in_valid;
    logic                 core_in_ready;
    logic [A_WIDTH-1:0]   core_a;
    logic [B_WIDTH-1:0]   core_b;
    logic                 core_out_valid;
    logic                 core_out_ready;
    logic [ACC_WIDTH-1:0] core_out_data;

    logic                 res_wr_valid;
    logic                 res_wr_ready;
    logic [ADDR_W-1:0]    res_wr_addr;
    logic [ACC_WIDTH-1:0] res_wr_data;

    modport master (
        output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        output core_start, core_k_tile, core_in_valid, core_a, core_b, core_out_ready,
        output res_wr_valid, res_wr_addr, res_wr_data,
        input  a_rd_data, b_rd_data, core_in_ready, core_out_valid, core_out_data, res_wr_ready
    );

    modport slave (
        input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        input  core_start, core_k_tile, core_in_valid, core_a, core_b, core_out_ready,
        input  res_wr_valid, res_wr_addr, res_wr_data,
        output a_rd_data, b_rd_data, core_in_ready, core_out_valid, core_out_data, res_wr_ready
    );
endinterface

// File: rtl/gemm_operand_fetch.sv
// Operand fetch for one output element: issues paired A/B reads and holds
// the returned pair in a one-entry register until the core accepts it.
module gemm_operand_fetch #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_active,
    input  logic [15:0]        i_k_eff,
    input  logic [A_WIDTH-1:0] i_a_data,
    input  logic [B_WIDTH-1:0] i_b_data,
    input  logic               i_in_ready,
    output logic               o_rd_en,
    output logic [15:0]        o_rd_k,
    output logic               o_in_valid,
    output logic [A_WIDTH-1:0] o_a,
    output logic [B_WIDTH-1:0] o_b,
    output logic               o_last_fire
);
    logic               r_pend;
    logic               r_vld;
    logic [A_WIDTH-1:0] r_a;
    logic [B_WIDTH-1:0] r_b;
    logic [15:0]        r_rd_cnt;
    logic [15:0]        r_fire_cnt;
    logic               w_fire;

    // The entry is occupied while a read is in flight or data is held; the
    // arriving read is presented directly so one pair can fire every cycle.
    assign o_in_valid  = r_vld | r_pend;
    assign o_a         = r_vld ? r_a : (r_pend ? i_a_data : '0);
    assign o_b         = r_vld ? r_b : (r_pend ? i_b_data : '0);
    assign w_fire      = o_in_valid & i_in_ready;
    assign o_rd_en     = i_active & (r_rd_cnt < i_k_eff) & (~o_in_valid | w_fire);
    assign o_rd_k      = r_rd_cnt;
    assign o_last_fire = w_fire & (r_fire_cnt == i_k_eff - 16'd1);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_pend     <= 1'b0;
            r_vld      <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_rd_cnt   <= '0;
            r_fire_cnt <= '0;
        end else begin
            r_pend <= o_rd_en;
            if (o_rd_en) r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_fire) r_fire_cnt <= r_fire_cnt + 16'd1;
            if (r_pend && !w_fire) begin
                r_vld <= 1'b1;
                r_a   <= i_a_data;
                r_b   <= i_b_data;
            end else if (w_fire) begin
                r_vld <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/gemm_tile_sched.sv
// GEMM tile scheduler: walks the Me x Ne output tile row-major, feeds Ke
// operand pairs per element to the core and writes each result back.
// Optional perf counters are built when GEMM_SCHED_PERF_EN is defined.
module gemm_tile_sched
    import gemm_pkg::*;
#(
    parameter int M_TILE    = DEF_M_TILE,
    parameter int N_TILE    = DEF_N_TILE,
    parameter int K_TILE    = DEF_K_TILE,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 32,
    parameter int ADDR_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cfg_m,
    input  logic [15:0] cfg_n,
    input  logic [15:0] cfg_k,
    output logic        busy,
    output logic        done,
    output logic [31:0] perf_job_cycles,
    output logic [31:0] perf_stall_cycles,
    gemm_tile_sched_if.master bus
);
    sched_state_t         r_state, w_next;
    logic [15:0]          r_me, r_ne, r_ke, r_m, r_n;
    logic [ACC_WIDTH-1:0] r_res;
    logic                 w_start_acc, w_last_elem, w_elem_start, w_feed;
    logic                 w_rd_en, w_in_valid, w_last_fire;
    logic [15:0]          w_rd_k;
    logic [A_WIDTH-1:0]   w_core_a;
    logic [B_WIDTH-1:0]   w_core_b;
    logic [ADDR_W-1:0]    w_a_addr, w_b_addr;

    assign w_start_acc = start && (r_state == IDLE);
    assign w_last_elem = (r_m == r_me - 16'd1) && (r_n == r_ne - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next              = r_state;
        busy                = 1'b1;
        done                = 1'b0;
        bus.core_start      = 1'b0;
        bus.core_out_ready  = 1'b0;
        bus.res_wr_valid    = 1'b0;
        w_elem_start        = 1'b0;
        w_feed              = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = ELEM_START;
            end
            ELEM_START: begin
                bus.core_start = 1'b1;
                w_elem_start   = 1'b1;
                w_next         = FEED;
            end
            FEED: begin
                w_feed = 1'b1;
                if (w_last_fire) w_next = WAIT_OUT;
            end
            WAIT_OUT: begin
                bus.core_out_ready = 1'b1;
                if (bus.core_out_valid) w_next = WRITE;
            end
            WRITE: begin
                bus.res_wr_valid = 1'b1;
                if (bus.res_wr_ready) w_next = w_last_elem ? FIN : ELEM_START;
            end
            FIN: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_me  <= '0;
            r_ne  <= '0;
            r_ke  <= '0;
            r_m   <= '0;
            r_n   <= '0;
            r_res <= '0;
        end else begin
            if (w_start_acc) begin
                r_me <= clamp_dim(cfg_m, 16'(M_TILE));
                r_ne <= clamp_dim(cfg_n, 16'(N_TILE));
                r_ke <= clamp_dim(cfg_k, 16'(K_TILE));
                r_m  <= '0;
                r_n  <= '0;
            end
            if (r_state == WAIT_OUT && bus.core_out_valid) r_res <= bus.core_out_data;
            if (r_state == WRITE && bus.res_wr_ready && !w_last_elem) begin
                if (r_n == r_ne - 16'd1) begin
                    r_n <= '0;
                    r_m <= r_m + 16'd1;
                end else begin
                    r_n <= r_n + 16'd1;
                end
            end
        end
    end

    gemm_operand_fetch #(.A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH)) u_fetch (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_elem_start),
        .i_active    (w_feed),
        .i_k_eff     (r_ke),
        .i_a_data    (bus.a_rd_data),
        .i_b_data    (bus.b_rd_data),
        .i_in_ready  (bus.core_in_ready),
        .o_rd_en     (w_rd_en),
        .o_rd_k      (w_rd_k),
        .o_in_valid  (w_in_valid),
        .o_a         (w_core_a),
        .o_b         (w_core_b),
        .o_last_fire (w_last_fire)
    );

    assign w_a_addr = ADDR_W'(r_m) * ADDR_W'(r_ke) + ADDR_W'(w_rd_k);
    assign w_b_addr = ADDR_W'(w_rd_k) * ADDR_W'(r_ne) + ADDR_W'(r_n);

    assign bus.a_rd_en       = w_rd_en;
    assign bus.b_rd_en       = w_rd_en;
    assign bus.a_rd_addr     = w_rd_en ? w_a_addr : '0;
    assign bus.b_rd_addr     = w_rd_en ? w_b_addr : '0;
    assign bus.core_k_tile   = r_ke;
    assign bus.core_in_valid = w_in_valid;
    assign bus.core_a        = w_core_a;
    assign bus.core_b        = w_core_b;
    assign bus.res_wr_addr   = ADDR_W'(r_m) * ADDR_W'(r_ne) + ADDR_W'(r_n);
    assign bus.res_wr_data   = r_res;

`ifdef GEMM_SCHED_PERF_EN
    logic [31:0] r_job_cyc, r_stall_cyc;
    logic        w_stall;

    assign w_stall = (bus.core_in_valid & ~bus.core_in_ready) |
                     (bus.res_wr_valid & ~bus.res_wr_ready);

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_job_cyc   <= '0;
            r_stall_cyc <= '0;
        end else begin
            if (busy && r_job_cyc != '1) r_job_cyc <= r_job_cyc + 32'd1;
            if (w_stall && r_stall_cyc != '1) r_stall_cyc <= r_stall_cyc + 32'd1;
        end
    end

    assign perf_job_cycles   = r_job_cyc;
    assign perf_stall_cycles = r_stall_cyc;
`else
    assign perf_job_cycles   = '0;
    assign perf_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_gemm_tile_sched.sv
// Self-checking bench for gemm_tile_sched: buffer/core models plus operand
// and result scoreboards, driven by a table of jobs and corner-case sequences.
module tb_gemm_tile_sched;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] cfg_m, cfg_n, cfg_k;
    logic        busy, done;
    logic [31:0] perf_job_cycles, perf_stall_cycles;

    always #5 clk = ~clk;

    gemm_tile_sched_if bus ();

    gemm_tile_sched dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .cfg_m             (cfg_m),
        .cfg_n             (cfg_n),
        .cfg_k             (cfg_k),
        .busy              (busy),
        .done              (done),
        .perf_job_cycles   (perf_job_cycles),
        .perf_stall_cycles (perf_stall_cycles),
        .bus               (bus)
    );

    typedef struct packed { logic [15:0] a; logic [7:0] b; } op_t;
    typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;
    typedef struct {
        int cm, cn, ck, mode;
        bit bp;
        int exp_w, exp_f;
        bit chk_last;
        int exp_last;
    } vec_t;

    op_t  op_q[$];
    wr_t  wr_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   n_fires = 0, n_writes = 0, n_done = 0, n_cstart = 0, n_reads = 0;
    int   last_wr = 0;
    bit   rnd_bp = 1'b0;
    logic [15:0] amem [256];
    logic [7:0]  bmem [256];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // A/B buffers: registered read, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.a_rd_en) bus.a_rd_data <= amem[bus.a_rd_addr[7:0]];
        if (bus.b_rd_en) bus.b_rd_data <= bmem[bus.b_rd_addr[7:0]];
    end

    // MAC core model: accumulates k_tile products, then offers the sum.
    logic signed [31:0] c_acc, w_prod;
    int c_cnt, c_k;
    assign w_prod = $signed(bus.core_a) * $signed(bus.core_b);
    always @(posedge clk) begin
        if (rst) begin
            bus.core_out_valid <= 1'b0;
            bus.core_out_data  <= '0;
            c_acc <= '0; c_cnt <= 0; c_k <= 0;
        end else begin
            if (bus.core_out_valid && bus.core_out_ready) bus.core_out_valid <= 1'b0;
            if (bus.core_start) begin
                c_acc <= '0; c_cnt <= 0; c_k <= int'(bus.core_k_tile);
            end else if (bus.core_in_valid && bus.core_in_ready) begin
                c_acc <= c_acc + w_prod;
                c_cnt <= c_cnt + 1;
                if (c_cnt + 1 == c_k) begin
                    bus.core_out_valid <= 1'b1;
                    bus.core_out_data  <= c_acc + w_prod;
                end
            end
        end
    end

    // Ready drivers change just after the active edge.
    initial begin
        bus.core_in_ready = 1'b1;
        bus.res_wr_ready  = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.core_in_ready = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.res_wr_ready  = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshakes seen at negedge are the ones taken at the next edge.
    op_t  m_op;
    wr_t  m_wr;
    bit   hold_in = 0, hold_wr = 0;
    logic [15:0] h_a, h_waddr;
    logic [7:0]  h_b;
    logic [31:0] h_wdata;
    always @(negedge clk) begin
        if (rst) begin
            hold_in = 0; hold_wr = 0;
        end else begin
            if (hold_in) begin
                check("in_hold_valid", bus.core_in_valid, 1);
                check("in_hold_a", bus.core_a, h_a);
                check("in_hold_b", bus.core_b, h_b);
            end
            if (hold_wr) begin
                check("wr_hold_valid", bus.res_wr_valid, 1);
                check("wr_hold_addr", bus.res_wr_addr, h_waddr);
                check("wr_hold_data", bus.res_wr_data, h_wdata);
            end
            hold_in = bus.core_in_valid && !bus.core_in_ready;
            hold_wr = bus.res_wr_valid && !bus.res_wr_ready;
            h_a = bus.core_a; h_b = bus.core_b;
            h_waddr = bus.res_wr_addr; h_wdata = bus.res_wr_data;
            if (bus.a_rd_en || bus.b_rd_en) begin
                n_reads++;
                check("rd_en_pair", bus.a_rd_en, bus.b_rd_en);
            end
            if (bus.core_start) n_cstart++;
            if (done) n_done++;
            if (bus.core_in_valid && bus.core_in_ready) begin
                n_fires++;
                if (op_q.size() == 0) check("op_extra", 1, 0);
                else begin
                    m_op = op_q.pop_front();
                    check("op_a", bus.core_a, m_op.a);
                    check("op_b", bus.core_b, m_op.b);
                end
            end
            if (bus.res_wr_valid && bus.res_wr_ready) begin
                n_writes++;
                last_wr = int'(bus.res_wr_data);
                if (wr_q.size() == 0) check("wr_extra", 1, 0);
                else begin
                    m_wr = wr_q.pop_front();
                    check("wr_addr", bus.res_wr_addr, m_wr.addr);
                    check("wr_data", bus.res_wr_data, m_wr.data);
                end
            end
        end
    end

    function automatic int eff(input int c, input int mx);
        return (c == 0 || c > mx) ? mx : c;
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0: begin amem[i] = 16'(i + 1); bmem[i] = 8'd1; end
                1: begin amem[i] = '0; bmem[i] = '0; end
                default: begin
                    amem[i] = 16'($urandom_range(0, 65535));
                    bmem[i] = 8'($urandom_range(0, 255));
                end
            endcase
        end
        if (mode == 1) begin
            amem[0] = 16'd2; amem[1] = 16'hFFFD; amem[2] = 16'd4;
            bmem[0] = 8'd5;  bmem[1] = 8'd6;     bmem[2] = 8'hF9;
        end
    endtask

    task automatic push_expected(input int me, ne, ke);
        int acc;
        for (int m = 0; m < me; m++)
            for (int n = 0; n < ne; n++) begin
                acc = 0;
                for (int k = 0; k < ke; k++) begin
                    op_q.push_back('{a: amem[m*ke+k], b: bmem[k*ne+n]});
                    acc += int'($signed(amem[m*ke+k])) * int'($signed(bmem[k*ne+n]));
                end
                wr_q.push_back('{addr: 16'(m*ne+n), data: acc});
            end
    endtask

    task automatic pulse_start(input int cm, cn, ck);
        @(posedge clk); #1;
        start = 1'b1; cfg_m = 16'(cm); cfg_n = 16'(cn); cfg_k = 16'(ck);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input string tag, input int cm, cn, ck, exp_w, exp_f, input bit poke);
        int me, ne, ke, w0, f0, d0, c0, t;
        me = eff(cm, 4); ne = eff(cn, 8); ke = eff(ck, 16);
        push_expected(me, ne, ke);
        w0 = n_writes; f0 = n_fires; d0 = n_done; c0 = n_cstart;
        pulse_start(cm, cn, ck);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_core_start"}, bus.core_start, 1);
        check({tag, "_k_tile"}, bus.core_k_tile, ke);
        if (poke) begin
            t = 0;
            while (n_cstart < c0 + 2 && t < 2000) begin @(negedge clk); t++; end
            pulse_start(1, 1, 1);
        end
        t = 0;
        while (n_done == d0 && t < 20000) begin @(negedge clk); t++; end
        check({tag, "_finished"}, t < 20000, 1);
        repeat (3) @(negedge clk);
        check({tag, "_writes"}, n_writes - w0, exp_w);
        check({tag, "_fires"}, n_fires - f0, exp_f);
        check({tag, "_elem_starts"}, n_cstart - c0, exp_w);
        check({tag, "_done_pulses"}, n_done - d0, 1);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_op_left"}, op_q.size(), 0);
        check({tag, "_wr_left"}, wr_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, {bus.a_rd_en, bus.b_rd_en}, 0);
        check({tag, "_rd_addr"}, {bus.a_rd_addr, bus.b_rd_addr}, 0);
        check({tag, "_core_ctl"}, {bus.core_start, bus.core_in_valid, bus.core_out_ready}, 0);
        check({tag, "_core_ops"}, {bus.core_a, bus.core_b, bus.core_k_tile}, 0);
        check({tag, "_wr"}, {bus.res_wr_valid, bus.res_wr_addr}, 0);
        check({tag, "_wr_data"}, bus.res_wr_data, 0);
        check({tag, "_perf"}, {perf_job_cycles, perf_stall_cycles}, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int r0, w0, c0, t;
        vecs[0] = '{0, 0, 0, 0, 1'b0, 32, 512, 1'b1, 904};
        vecs[1] = '{1, 1, 3, 1, 1'b0, 1, 3, 1'b1, -36};
        vecs[2] = '{9, 20, 40, 2, 1'b0, 32, 512, 1'b0, 0};
        vecs[3] = '{0, 0, 0, 0, 1'b1, 32, 512, 1'b1, 904};
        vecs[4] = '{2, 3, 5, 2, 1'b1, 6, 30, 1'b0, 0};
        vecs[5] = '{4, 8, 16, 2, 1'b1, 32, 512, 1'b0, 0};

        rst = 1'b1; start = 1'b0; cfg_m = '0; cfg_n = '0; cfg_k = '0;
        fill(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        foreach (vecs[i]) begin
            rnd_bp = vecs[i].bp;
            fill(vecs[i].mode);
            run_job($sformatf("job%0d", i), vecs[i].cm, vecs[i].cn, vecs[i].ck,
                    vecs[i].exp_w, vecs[i].exp_f, 1'b0);
            if (vecs[i].chk_last) check($sformatf("job%0d_last_data", i), last_wr, vecs[i].exp_last);
        end

        // Start pulsed mid-job must not disturb the running 2x2x2 job.
        rnd_bp = 1'b0;
        fill(2);
        run_job("busy_start", 2, 2, 2, 4, 8, 1'b1);

        // Reset while element 5 is being fed abandons the job.
        fill(0);
        push_expected(4, 8, 16);
        c0 = n_cstart;
        pulse_start(0, 0, 0);
        t = 0;
        while (n_cstart < c0 + 6 && t < 2000) begin @(negedge clk); t++; end
        check("midrst_reached_elem5", t < 2000, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        op_q.delete(); wr_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        r0 = n_reads; w0 = n_writes; c0 = n_cstart;
        repeat (40) @(negedge clk);
        check("midrst_no_reads", n_reads - r0, 0);
        check("midrst_no_writes", n_writes - w0, 0);
        check("midrst_no_starts", n_cstart - c0, 0);
        run_job("after_rst", 0, 0, 0, 32, 512, 1'b0);
        check("after_rst_last_data", last_wr, 904);

        // Minimal stall-free job for the perf counters.
        fill(2);
        run_job("perf111", 1, 1, 1, 1, 1, 1'b0);
`ifdef GEMM_SCHED_PERF_EN
        check("perf_job_cycles", perf_job_cycles, 6);
        check("perf_stall_cycles", perf_stall_cycles, 0);
`else
        check("perf_job_cycles", perf_job_cycles, 0);
        check("perf_stall_cycles", perf_stall_cycles, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
